camera_pixel_reconstruct: RTL
=============================

// Module: camera_pixel_reconstruct
// PURPOSE
//  Upstream of the frame-buffer read/scale stage. Rebuilds 16-bit RGB565 pixels
//  from the camera's 8-bit byte stream (two bytes per pixel, high byte first).
//  Tags each pixel with its hcount/vcount and emits a one-cycle write strobe
//  for the frame buffer, whose read side feeds the scale/crop stage.
//  Camera inputs arrive already synchronised to clk_in; pclk is edge-detected here.
// PARAMETERS
//  HCOUNT_WIDTH  11    width of pixel_hcount_out
//  VCOUNT_WIDTH  10    width of pixel_vcount_out
//  MAX_H         1280  active pixels per line (bounds checking only)
//  MAX_V         720   active lines per frame (bounds checking only)
// PORTS
//  clk_in            in   1             system clock
//  rst_n_in          in   1             async active-low reset
//  camera_pclk_in    in   1             synchronised camera pixel clock
//  camera_hs_in      in   1             line active, high during valid bytes
//  camera_vs_in      in   1             frame active, high during frame
//  camera_data_in    in   8             camera byte; valid at pclk rising edge
//  pixel_valid_out   out  1             one-cycle strobe, pixel fields valid
//  pixel_hcount_out  out  HCOUNT_WIDTH  column of emitted pixel
//  pixel_vcount_out  out  VCOUNT_WIDTH  row of emitted pixel
//  pixel_data_out    out  16            RGB565, {hi_byte, lo_byte}
//  overflow_out      out  1             sticky out-of-bounds flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n_in low): all outputs 0, state WAIT_FRAME, counters 0,
//    pclk_prev 0. Reset mid-frame discards any partial pixel and the rest of the
//    frame; the block resyncs on the next vs rising edge.
//  - Edge: pclk_rise = camera_pclk_in & ~pclk_prev. hs/vs/data sampled only on
//    pclk_rise cycles; nothing advances otherwise.
//  - States:
//    WAIT_FRAME: on pclk_rise with vs=1 and vs_prev=0 -> BYTE_HI; hcount=vcount=0.
//      vs already high out of reset is ignored; wait for low then high.
//    BYTE_HI: pclk_rise, vs=1, hs=1: latch data as hi byte -> BYTE_LO.
//    BYTE_LO: pclk_rise, vs=1, hs=1: pixel_data_out={hi,data}, fields set,
//      pixel_valid_out=1 next cycle -> BYTE_HI.
//    Any state != WAIT_FRAME, pclk_rise with vs=0 -> WAIT_FRAME.
//  - Line end: pclk_rise with hs=0, hs_prev=1: hcount=0, vcount+1, state BYTE_HI.
//    An orphan hi byte (line ends in BYTE_LO) is dropped, no strobe.
//  - hcount increments after each emitted pixel; counters wrap modulo 2^width.
//  - Latency: pixel_valid_out high exactly the clk_in cycle after the pclk_rise
//    that sampled the lo byte; low every other cycle. Fields hold until next strobe.
//  - hs_prev/vs_prev update only on pclk_rise. Two pclk_rise never adjacent
//    (pclk <= clk_in/2); no back-pressure, the sink must accept every strobe.
// CONFIGURATION
//  PIXEL_RECON_BOUNDS_EN defined: pixels with hcount>=MAX_H or vcount>=MAX_V are
//    not strobed; overflow_out set sticky, cleared on next frame start (vs rise).
//    Counters saturate at MAX_H / MAX_V instead of wrapping.
//  Not defined: no bounds check, counters wrap, overflow_out tied 0.
// TESTING
//  1 Reset then vs rise, hs high, bytes A1,B2,C3,D4 -> strobes {A1B2}@(0,0),
//    {C3D4}@(1,0); each strobe 1 clk after 2nd byte's pclk_rise, width 1 cycle.
//  2 Line of 3 bytes then hs low -> 1 pixel emitted, orphan dropped; next line
//    first pixel at hcount 0, vcount 1.
//  3 vs already high at reset release -> no strobes until vs low then high;
//    then first pixel at (0,0).
//  4 Assert rst_n_in mid-pixel (after hi byte) -> outputs 0 immediately, no
//    strobe; next frame decodes correctly from (0,0).
//  5 BOUNDS_EN, MAX_H=4: line of 6 pixels -> 4 strobes (h 0..3), overflow_out=1,
//    cleared on next vs rise; without macro 6 strobes, overflow_out stays 0.
//  6 pclk toggling every 2 clk_in, 640x480 frame -> 307200 strobes, last at
//    (639,479), data matches incrementing byte pattern.

Source files
------------

// File: rtl/camera_pixel_reconstruct_if.sv
// Camera byte stream in, reconstructed RGB565 pixel strobe out.
// master drives the camera side and consumes pixels; slave is the reconstruct block.
interface camera_pixel_reconstruct_if #(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
);
  logic                    camera_pclk_in;
  logic                    camera_hs_in;
  logic                    camera_vs_in;
  logic [7:0]              camera_data_in;
  logic                    pixel_valid_out;
  logic [HCOUNT_WIDTH-1:0] pixel_hcount_out;
  logic [VCOUNT_WIDTH-1:0] pixel_vcount_out;
  logic [15:0]             pixel_data_out;
  logic                    overflow_out;

  modport master (
    output camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in,
    input  pixel_valid_out, pixel_hcount_out, pixel_vcount_out, pixel_data_out, overflow_out
  );

  modport slave (
    input  camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in,
    output pixel_valid_out, pixel_hcount_out, pixel_vcount_out, pixel_data_out, overflow_out
  );
endinterface

// File: rtl/camera_pixel_reconstruct.sv
// Rebuilds RGB565 pixels from the camera byte stream and tags them with column/row.
// Define PIXEL_RECON_BOUNDS_EN to drop out-of-range pixels, saturate counters and flag overflow.
module camera_pixel_reconstruct #(
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10,
  parameter int MAX_H        = 1280,
  parameter int MAX_V        = 720
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  camera_pixel_reconstruct_if.slave  cam
);

`ifdef PIXEL_RECON_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [HCOUNT_WIDTH-1:0] MAX_H_C = HCOUNT_WIDTH'(MAX_H);
  localparam logic [VCOUNT_WIDTH-1:0] MAX_V_C = VCOUNT_WIDTH'(MAX_V);

  typedef enum logic [1:0] {WAIT_FRAME, BYTE_HI, BYTE_LO} state_t;

  state_t                  state_reg;
  logic                    pclk_prev_reg;
  logic                    hs_prev_reg;
  logic                    vs_prev_reg;
  logic [7:0]              hi_byte_reg;
  logic [HCOUNT_WIDTH-1:0] hcount_reg;
  logic [VCOUNT_WIDTH-1:0] vcount_reg;
  logic                    pixel_valid_reg;
  logic [HCOUNT_WIDTH-1:0] pixel_hcount_reg;
  logic [VCOUNT_WIDTH-1:0] pixel_vcount_reg;
  logic [15:0]             pixel_data_reg;
  logic                    overflow_reg;

  logic                    pclk_rise;
  logic                    in_bounds;
  logic [HCOUNT_WIDTH-1:0] hcount_next;
  logic [VCOUNT_WIDTH-1:0] vcount_next;

  assign pclk_rise = cam.camera_pclk_in & ~pclk_prev_reg;

  always_comb begin
    in_bounds   = !BOUNDS_EN || ((hcount_reg < MAX_H_C) && (vcount_reg < MAX_V_C));
    hcount_next = hcount_reg + 1'b1;
    vcount_next = vcount_reg + 1'b1;
    if (BOUNDS_EN && (hcount_reg >= MAX_H_C)) hcount_next = MAX_H_C;
    if (BOUNDS_EN && (vcount_reg >= MAX_V_C)) vcount_next = MAX_V_C;
  end

  // vs_prev resets high so a frame already in progress at reset is skipped
  // until vs has been seen low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg        <= WAIT_FRAME;
      pclk_prev_reg    <= 1'b0;
      hs_prev_reg      <= 1'b0;
      vs_prev_reg      <= 1'b1;
      hi_byte_reg      <= '0;
      hcount_reg       <= '0;
      vcount_reg       <= '0;
      pixel_valid_reg  <= 1'b0;
      pixel_hcount_reg <= '0;
      pixel_vcount_reg <= '0;
      pixel_data_reg   <= '0;
      overflow_reg     <= 1'b0;
    end else begin
      pclk_prev_reg   <= cam.camera_pclk_in;
      pixel_valid_reg <= 1'b0;
      if (pclk_rise) begin
        hs_prev_reg <= cam.camera_hs_in;
        vs_prev_reg <= cam.camera_vs_in;
        if (state_reg == WAIT_FRAME) begin
          if (cam.camera_vs_in && !vs_prev_reg) begin
            state_reg    <= BYTE_HI;
            hcount_reg   <= '0;
            vcount_reg   <= '0;
            overflow_reg <= 1'b0;
          end
        end else if (!cam.camera_vs_in) begin
          state_reg <= WAIT_FRAME;
        end else if (!cam.camera_hs_in && hs_prev_reg) begin
          // line end also drops any orphan high byte
          state_reg  <= BYTE_HI;
          hcount_reg <= '0;
          vcount_reg <= vcount_next;
        end else if (cam.camera_hs_in) begin
          if (state_reg == BYTE_HI) begin
            hi_byte_reg <= cam.camera_data_in;
            state_reg   <= BYTE_LO;
          end else begin
            state_reg  <= BYTE_HI;
            hcount_reg <= hcount_next;
            if (in_bounds) begin
              pixel_valid_reg  <= 1'b1;
              pixel_hcount_reg <= hcount_reg;
              pixel_vcount_reg <= vcount_reg;
              pixel_data_reg   <= {hi_byte_reg, cam.camera_data_in};
            end else begin
              overflow_reg <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign cam.pixel_valid_out  = pixel_valid_reg;
  assign cam.pixel_hcount_out = pixel_hcount_reg;
  assign cam.pixel_vcount_out = pixel_vcount_reg;
  assign cam.pixel_data_out   = pixel_data_reg;
  assign cam.overflow_out     = overflow_reg;

endmodule
